// File: rtl/cla2_serial_sequencer.sv
// Multi-cycle W-bit adder: one 2-bit carry-lookahead slice per cycle, LSB slice first.
// Optional signed-overflow output enabled by defining CLA2_SEQ_OVF_EN.
module cla2_serial_sequencer #(
    parameter int W = 8,
    localparam int CW = (W / 2 > 1) ? $clog2(W / 2) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef CLA2_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;

    logic          accept;
    logic          last;
    logic [1:0]    a_sl;
    logic [1:0]    b_sl;
    logic [1:0]    g;
    logic [1:0]    p;
    logic          c1;
    logic          c2;

    // DONE accepts a new start just like IDLE, giving back-to-back operation.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(W / 2 - 1));

    assign a_sl = a_r[{cnt, 1'b0} +: 2];
    assign b_sl = b_r[{cnt, 1'b0} +: 2];
    assign g    = a_sl & b_sl;
    assign p    = a_sl ^ b_sl;
    assign c1   = g[0] | (p[0] & carry);
    assign c2   = g[1] | (p[1] & c1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CLA2_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CLA2_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == RUN) begin
            sum[{cnt, 1'b0} +: 2] <= {p[1] ^ c1, p[0] ^ carry};
            carry <= c2;
            if (last) begin
                cout <= c2;
`ifdef CLA2_SEQ_OVF_EN
                // Carry into the MSB differs from carry out of it on signed overflow.
                ovf  <= c1 ^ c2;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
